bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side sequencer for the team's single-port BRAM.
- On a start command it walks a contiguous address range, drives BRAM address/write-enable, and absorbs the fixed 1-cycle read latency.
- Returns the words as a valid/ready stream with last marker and backpressure, e.g. streaming a 784-pixel MNIST image into the inference pipeline.
- A 2-entry output buffer guarantees no word is lost when the consumer stalls.

Parameters:
- DataWidth, 8, BRAM word width and stream data width.
- Depth, 784, BRAM word count; AddrWidth = $clog2(Depth+1), matching the BRAM address port.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start command pulse; sampled only in IDLE.
- base_addr_i  in  AddrWidth  first word address; sampled with start_i.
- len_i  in  AddrWidth  word count; sampled with start_i.
- busy_o  out  1  high from the cycle after start is accepted until done.
- done_o  out  1  one-cycle pulse on completion.
- bram_addr_o  out  AddrWidth  BRAM address.
- bram_write_en_o  out  1  BRAM write enable; tied 0.
- bram_data_o  out  DataWidth  BRAM write data; tied 0.
- bram_data_i  in  DataWidth  BRAM read data, valid one cycle after the address.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- m_data_o  out  DataWidth  stream data.
- m_last_o  out  1  high with the final word of the burst.

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0, FIFO empty, in-flight flag 0. Outputs low: busy_o, done_o, m_valid_o, m_last_o, bram_addr_o (0), m_data_o (0).
- States: IDLE, READ, DRAIN.
- IDLE, start_i=1, len_i>0: latch base/len, go to READ, busy_o=1 next cycle.
- IDLE, start_i=1, len_i=0: no reads issued; done_o pulses next cycle; stay IDLE.
- start_i outside IDLE is ignored; latched base/len are not disturbed.
- READ issue rule: issue a read when occupancy + inflight - pop < 2, where pop = m_valid_o & m_ready_i.
  - On issue: bram_addr_o = current address, inflight set for one cycle, address advances.
  - Address wraps Depth-1 -> 0.
- Data capture: bram_data_i is pushed into the 2-entry FIFO in the cycle after issue, tagged last if it is the len-th word.
- After the len-th issue, go to DRAIN.
- DRAIN: wait until inflight=0 and FIFO is empty.
  - Completion is the cycle the last word handshakes.
  - done_o pulses the next cycle; busy_o falls in that same cycle; return to IDLE.
- Latency: start sampled at edge 0, first read issued in cycle 1, m_valid_o first high in cycle 3.
- Throughput: with m_ready_i held high, 1 word/cycle sustained.
- Stream rule: m_data_o and m_last_o hold stable while m_valid_o=1 and m_ready_i=0. m_valid_o never drops without a handshake.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Reset mid-burst: everything returns to the reset values immediately; the in-flight read is discarded.

Optional Feature:
- Macro: BRAM_READER_ABORT_EN.
- Defined: adds input abort_i (1 bit).
  - abort_i=1 in READ or DRAIN: flush the FIFO, discard the in-flight word, return to IDLE next cycle.
  - m_valid_o and busy_o fall next cycle; done_o is not pulsed.
  - abort_i is ignored in IDLE and has priority over a same-cycle handshake.
- Undefined: port absent; a burst always completes.

Test Plan:
- mem[i]=i+10, base=0, len=4, ready=1 -> data 10,11,12,13 on consecutive cycles; m_last_o only on 13; done_o pulse 1 cycle after the 13 handshake.
- base=5, len=6, m_ready_i toggling 1,0,0,1,... -> exactly mem[5..10] in order, no duplicates or drops; data stable through stalls; FIFO occupancy never exceeds 2.
- len=0 start -> no m_valid_o; done_o pulses next cycle; busy_o stays 0.
- base=782, Depth=784, len=4 -> addresses 782, 783, 0, 1; data mem[782], mem[783], mem[0], mem[1].
- Second start_i pulse mid-burst with base=100 -> ignored; original burst completes unchanged. Then rst_ni low mid-burst -> m_valid_o and busy_o drop immediately; a new start after release streams correctly.
- With BRAM_READER_ABORT_EN: abort_i after 2 of 8 words -> m_valid_o=0 next cycle, no done_o; a following len=3 burst yields the correct 3 words.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a BRAM address range and returns the words as a valid/ready stream.
// Optional abort input is enabled by defining BRAM_READER_ABORT_EN.
module bram_stream_reader #(
  parameter int DataWidth = 8,
  parameter int Depth = 784,
  localparam int AddrWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] len_i,
`ifdef BRAM_READER_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] bram_addr_o,
  output logic                 bram_write_en_o,
  output logic [DataWidth-1:0] bram_data_o,
  input  logic [DataWidth-1:0] bram_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_last_o
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AddrWidth-1:0] addr_q, cnt_q;
  logic inflight_q, inflight_last_q, done_q, done_d;
  logic [DataWidth-1:0] fifo_data_q [2];
  logic [1:0] fifo_last_q, count_q;
  logic rd_ptr_q, wr_ptr_q;
  logic pop, issue, abort, last_issue;
`ifdef BRAM_READER_ABORT_EN
  assign abort = abort_i & (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif
  assign pop = m_valid_o & m_ready_i;
  // Keep occupancy plus the word still in the BRAM pipe within the two buffer slots.
  assign issue = (state_q == READ) & ~abort &
                 (({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  assign last_issue = issue & (cnt_q == AddrWidth'(1));
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign bram_addr_o = addr_q;
  assign bram_write_en_o = 1'b0;
  assign bram_data_o = '0;
  assign m_valid_o = count_q != 2'd0;
  assign m_data_o = fifo_data_q[rd_ptr_q];
  assign m_last_o = m_valid_o & fifo_last_q[rd_ptr_q];
  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Next state and completion pulse; abort overrides everything.
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && len_i != '0) state_d = READ;
        else if (start_i) done_d = 1'b1;
      end
      READ: if (last_issue) state_d = DRAIN;
      DRAIN: if (pop && m_last_o) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      done_d = 1'b0;
    end
  end
  // Address walk, read pipeline tracking and the two-entry output buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q <= '0;
      count_q <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      done_q <= done_d;
      inflight_q <= issue;
      inflight_last_q <= last_issue;
      if (state_q == IDLE && start_i) begin
        addr_q <= base_addr_i;
        cnt_q <= len_i;
      end else if (issue) begin
        addr_q <= (addr_q == AddrWidth'(Depth - 1)) ? '0 : addr_q + 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
      if (abort) begin
        count_q <= '0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (inflight_q) begin
          fifo_data_q[wr_ptr_q] <= bram_data_i;
          fifo_last_q[wr_ptr_q] <= inflight_last_q;
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
      end
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: table-driven bursts plus hand-written reset, len=0 and abort sequences.
module tb_bram_stream_reader;
  localparam int DW = 8;
  localparam int DEPTH = 784;
  localparam int AW = 10;
  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, m_ready_i = 1'b0, abort_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0, len_i = '0, bram_addr_o;
  logic busy_o, done_o, bram_write_en_o, m_valid_o, m_last_o;
  logic [DW-1:0] bram_data_o, m_data_o, bram_data_i = '0;
  logic [DW-1:0] mem [DEPTH];

  bram_stream_reader #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
`ifdef BRAM_READER_ABORT_EN
    .abort_i(abort_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .bram_addr_o(bram_addr_o),
    .bram_write_en_o(bram_write_en_o), .bram_data_o(bram_data_o),
    .bram_data_i(bram_data_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_last_o(m_last_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) bram_data_i <= mem[bram_addr_o];

  typedef struct {
    logic [9:0] base;
    logic [9:0] len;
    logic [7:0] pat;
    logic [7:0][7:0] exp;
    int last_cyc;
    int restart;
  } vec_t;
  vec_t vecs[6];

  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] got_d[$];
  logic got_l[$];
  int done_cnt, done_cyc, last_cyc, first_cyc, stab_err, busy_at_done;
  logic [9:0] addr_log[8];
  logic [9:0] wrap_addr[4];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_burst(input logic [9:0] base, input logic [9:0] len, input logic [7:0] pat,
                           input int restart);
    logic pv, pl;
    logic [7:0] pd;
    got_d.delete();
    got_l.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -1; first_cyc = -1; stab_err = 0; busy_at_done = -1;
    pv = 1'b0; pl = 1'b0; pd = '0;
    start_i = 1'b1; base_addr_i = base; len_i = len;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      start_i = (c == restart);
      if (c == restart) begin
        base_addr_i = 10'd100;
        len_i = 10'd2;
      end
      m_ready_i = pat[c % 8];
      #1;
      if (c < 8) addr_log[c] = bram_addr_o;
      if (pv && !(m_valid_o && m_data_o == pd && m_last_o == pl)) stab_err++;
      if (m_valid_o && first_cyc < 0) first_cyc = c;
      if (m_valid_o && m_ready_i) begin
        got_d.push_back(m_data_o);
        got_l.push_back(m_last_o);
        last_cyc = c;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = c;
        busy_at_done = int'(busy_o);
      end
      pv = m_valid_o & ~m_ready_i;
      pd = m_data_o;
      pl = m_last_o;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    m_ready_i = 1'b0;
  endtask

  task automatic check_burst(input string tag, input logic [9:0] len, input logic [7:0][7:0] exp,
                             input int exp_last);
    int nl;
    nl = 0;
    chk({tag, " count"}, got_d.size(), int'(len));
    for (int i = 0; i < got_d.size() && i < 8; i++)
      chk($sformatf("%s word%0d", tag, i), int'(got_d[i]), int'(exp[i]));
    foreach (got_l[i]) nl += int'(got_l[i]);
    chk({tag, " last_count"}, nl, 1);
    chk({tag, " last_on_final"}, got_l.size() > 0 ? int'(got_l[got_l.size()-1]) : 0, 1);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " done_timing"}, done_cyc, last_cyc + 1);
    chk({tag, " busy_at_done"}, busy_at_done, 0);
    chk({tag, " stall_stable"}, stab_err, 0);
    chk({tag, " first_valid"}, first_cyc, 2);
    if (exp_last >= 0) chk({tag, " last_cycle"}, last_cyc, exp_last);
  endtask

  initial begin
    int hs;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 10);
    vecs[0] = '{10'd0,   10'd4, 8'hFF, {8'd0, 8'd0, 8'd0, 8'd0, 8'd13, 8'd12, 8'd11, 8'd10}, 5, -1};
    vecs[1] = '{10'd5,   10'd6, 8'h99, {8'd0, 8'd0, 8'd20, 8'd19, 8'd18, 8'd17, 8'd16, 8'd15}, -1, -1};
    vecs[2] = '{10'd782, 10'd4, 8'hFF, {8'd0, 8'd0, 8'd0, 8'd0, 8'd11, 8'd10, 8'd25, 8'd24}, 5, -1};
    vecs[3] = '{10'd100, 10'd3, 8'h55, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd112, 8'd111, 8'd110}, -1, -1};
    vecs[4] = '{10'd783, 10'd2, 8'hFF, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd25}, 3, -1};
    vecs[5] = '{10'd0,   10'd6, 8'hFF, {8'd0, 8'd0, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10}, 7, 1};
    wrap_addr = '{10'd782, 10'd783, 10'd0, 10'd1};

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst valid", int'(m_valid_o), 0);
    chk("rst busy", int'(busy_o), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst last", int'(m_last_o), 0);
    chk("rst addr", int'(bram_addr_o), 0);
    chk("rst data", int'(m_data_o), 0);
    chk("rst wen", int'(bram_write_en_o), 0);
    chk("rst wdata", int'(bram_data_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].base, vecs[v].len, vecs[v].pat, vecs[v].restart);
      check_burst($sformatf("v%0d", v), vecs[v].len, vecs[v].exp, vecs[v].last_cyc);
      if (v == 2)
        for (int i = 0; i < 4; i++) chk($sformatf("wrap addr%0d", i), int'(addr_log[i]), int'(wrap_addr[i]));
    end

    start_i = 1'b1; base_addr_i = 10'd3; len_i = 10'd0; m_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("len0 done", int'(done_o), 1);
    chk("len0 busy", int'(busy_o), 0);
    chk("len0 valid", int'(m_valid_o), 0);
    @(negedge clk_i);
    #1;
    chk("len0 done_drop", int'(done_o), 0);
    chk("len0 valid_after", int'(m_valid_o), 0);

    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = 10'd0; len_i = 10'd8; m_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("midrst valid_before", int'(m_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst valid", int'(m_valid_o), 0);
    chk("midrst busy", int'(busy_o), 0);
    chk("midrst last", int'(m_last_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_burst(10'd20, 10'd3, 8'hFF, -1);
    check_burst("after_rst", 10'd3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd32, 8'd31, 8'd30}, 4);

`ifdef BRAM_READER_ABORT_EN
    start_i = 1'b1; base_addr_i = 10'd0; len_i = 10'd8; m_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    hs = 0;
    for (int c = 0; c < 10 && hs < 2; c++) begin
      #1;
      if (m_valid_o && m_ready_i) hs++;
      if (hs < 2) @(negedge clk_i);
    end
    chk("abort two_words", hs, 2);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    chk("abort valid", int'(m_valid_o), 0);
    chk("abort busy", int'(busy_o), 0);
    chk("abort done", int'(done_o), 0);
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      #1;
      hs += int'(done_o) + int'(m_valid_o);
    end
    chk("abort quiet", hs, 0);
    @(negedge clk_i);
    run_burst(10'd40, 10'd3, 8'hFF, -1);
    check_burst("after_abort", 10'd3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd52, 8'd51, 8'd50}, 4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
